// File: rtl/dot_product_pkg.sv
// Shared state encoding and width helpers for the dot-product sequencing controller.
package dot_product_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDrain  = 3'd2;
  localparam logic [2:0] StReduce = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  // Reduced sum of para_deg lanes of 2*data_width bits never overflows this width.
  function automatic int unsigned calc_out_w(input int unsigned dw, input int unsigned pd);
    return 2 * dw + $clog2(pd);
  endfunction

endpackage

// File: rtl/dot_lane_reducer.sv
// Lane snapshot buffer plus serial adder folding one lane per step into the scalar sum.
module dot_lane_reducer #(
  parameter int unsigned data_width = 8,
  parameter int unsigned para_deg   = 4,
  parameter int unsigned out_w      = 18,
  parameter int unsigned sel_w      = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_clear,
  input  logic                           i_capture,
  input  logic                           i_step,
  input  logic [sel_w-1:0]               i_sel,
  input  logic [para_deg*2*data_width-1:0] i_lanes,
  output logic [out_w-1:0]               o_sum
);

  localparam int unsigned LANE_W = 2 * data_width;

  logic [para_deg*LANE_W-1:0] r_lanes;
  logic [out_w-1:0]           r_sum;
  logic [LANE_W-1:0]          w_lane;

  assign w_lane = r_lanes[i_sel*LANE_W +: LANE_W];
  assign o_sum  = r_sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lanes <= '0;
    end else if (i_capture) begin
      r_lanes <= i_lanes;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_step) begin
      r_sum <= r_sum + out_w'(w_lane);
    end
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Sequences operand fetch for the MAC PE group, snapshots final lane values and
// reduces them serially into one dot product.
module dot_product_ctrl
  import dot_product_pkg::*;
#(
  parameter int unsigned data_width = 8,
  parameter int unsigned para_deg   = 4,
  parameter int unsigned addr_width = 8,
  localparam int unsigned OUT_W     = calc_out_w(data_width, para_deg)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  input  logic [addr_width:0]              i_len,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_rd_en,
  output logic [addr_width-1:0]            o_rd_addr,
  output logic                             o_pe_load_old,
  input  logic [para_deg*2*data_width-1:0] i_pe_result,
  output logic [OUT_W-1:0]                 o_dot_out,
  output logic                             o_dot_valid
);

  localparam int unsigned CNT_W = addr_width + 1;
  localparam int unsigned SEL_W = (para_deg > 1) ? $clog2(para_deg) : 1;

  logic [2:0]       r_state, w_state_d;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_pe_load_old;

  logic w_accept, w_fetch_last, w_drain_last, w_reduce_last;
  logic w_rd_en, w_capture, w_step;
  logic [addr_width-1:0] w_rd_addr;

  assign w_accept      = (r_state == StIdle) && i_start;
  assign w_fetch_last  = (r_cnt == r_len - CNT_W'(1));
  assign w_drain_last  = (r_cnt == CNT_W'(1));
  assign w_reduce_last = (r_cnt == CNT_W'(para_deg - 1));

  assign w_rd_en   = (r_state == StFetch);
  assign w_rd_addr = w_rd_en ? r_cnt[addr_width-1:0] : '0;
  // Last DRAIN cycle is the only one where the PE register holds the final sums.
  assign w_capture = (r_state == StDrain) && w_drain_last;
  assign w_step    = (r_state == StReduce);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_cnt_d   = '0;
          w_state_d = (i_len == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (w_fetch_last) begin
          w_cnt_d   = '0;
          w_state_d = StDrain;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StDrain: begin
        if (w_drain_last) begin
          w_cnt_d   = '0;
          w_state_d = StReduce;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StReduce: begin
        if (w_reduce_last) begin
          w_cnt_d   = '0;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StDone: begin
        w_cnt_d   = '0;
        w_state_d = StIdle;
      end
      default: begin
        w_cnt_d   = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_len         <= '0;
      r_pe_load_old <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_pe_load_old <= w_rd_en && (w_rd_addr != '0);
      if (w_accept) begin
        r_len <= i_len;
      end
    end
  end

  dot_lane_reducer #(
    .data_width (data_width),
    .para_deg   (para_deg),
    .out_w      (OUT_W),
    .sel_w      (SEL_W)
  ) u_reducer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_accept),
    .i_capture (w_capture),
    .i_step    (w_step),
    .i_sel     (r_cnt[SEL_W-1:0]),
    .i_lanes   (i_pe_result),
    .o_sum     (o_dot_out)
  );

  assign o_busy        = (r_state != StIdle);
  assign o_done        = (r_state == StDone);
  assign o_dot_valid   = o_done;
  assign o_rd_en       = w_rd_en;
  assign o_rd_addr     = w_rd_addr;
  assign o_pe_load_old = r_pe_load_old;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench for dot_product_ctrl with operand memories and PE group modelled in loop.
module tb_dot_product_ctrl;

  localparam int DW = 8;
  localparam int PD = 4;
  localparam int AW = 8;
  localparam int OW = 2 * DW + $clog2(PD);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW:0]       len;
  logic              busy, done, rd_en, load_old, dot_valid;
  logic [AW-1:0]     rd_addr;
  logic [PD*2*DW-1:0] pe_bus;
  logic [OW-1:0]     dot_out;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]   mem_a [256][PD];
  logic [DW-1:0]   mem_b [256][PD];
  logic [DW-1:0]   rda [PD];
  logic [DW-1:0]   rdb [PD];
  logic [2*DW-1:0] pe_res [PD];

  always #5 clk = ~clk;

  dot_product_ctrl #(
    .data_width (DW),
    .para_deg   (PD),
    .addr_width (AW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_len         (len),
    .o_busy        (busy),
    .o_done        (done),
    .o_rd_en       (rd_en),
    .o_rd_addr     (rd_addr),
    .o_pe_load_old (load_old),
    .i_pe_result   (pe_bus),
    .o_dot_out     (dot_out),
    .o_dot_valid   (dot_valid)
  );

  // Synchronous operand memories (latency 1) and registered MAC lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PD; i++) begin
        rda[i]    <= '0;
        rdb[i]    <= '0;
        pe_res[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PD; i++) begin
        if (rd_en) begin
          rda[i] <= mem_a[rd_addr][i];
          rdb[i] <= mem_b[rd_addr][i];
        end
        pe_res[i] <= (load_old ? pe_res[i] : 16'd0) + 16'(rda[i]) * 16'(rdb[i]);
      end
    end
  end

  always_comb begin
    pe_bus = '0;
    for (int i = 0; i < PD; i++) pe_bus[i*2*DW +: 2*DW] = pe_res[i];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: per-lane wrapped accumulation over the chunks, then plain sum of lanes.
  function automatic longint model(input int n);
    longint sum = 0;
    for (int i = 0; i < PD; i++) begin
      longint acc = 0;
      for (int k = 0; k < n; k++) acc = (acc + longint'(mem_a[k][i]) * longint'(mem_b[k][i])) % 65536;
      sum += acc;
    end
    return sum;
  endfunction

  task automatic fill_rand(input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < PD; i++) begin
        mem_a[k][i] = DW'($urandom_range(0, 255));
        mem_b[k][i] = DW'($urandom_range(0, 255));
      end
  endtask

  task automatic fill_const(input int n, input int a, input int b);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < PD; i++) begin
        mem_a[k][i] = DW'(a);
        mem_b[k][i] = DW'(b);
      end
  endtask

  // Accept at cycle S (c=0), then observe a bounded window cycle by cycle.
  task automatic run_op(input int n, input bit repulse, input string tag);
    longint exp_dot = model(n);
    int     exp_done = (n == 0) ? 1 : n + 3 + PD;
    int     win = n + PD + 6;
    @(negedge clk);
    start = 1'b1;
    len   = (AW + 1)'(n);
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      start = repulse && (c == 2 || c == n + 4);
      len   = (AW + 1)'($urandom_range(1, 256));
      check({tag, "_rd_en"}, 64'(rd_en), 64'(c <= n));
      if (c <= n) check({tag, "_rd_addr"}, 64'(rd_addr), 64'((c - 1) % 256));
      check({tag, "_load_old"}, 64'(load_old), 64'(c >= 3 && c <= n + 1));
      check({tag, "_done"}, 64'(done), 64'(c == exp_done));
      check({tag, "_busy"}, 64'(busy), 64'(c <= exp_done));
      if (c == exp_done) begin
        check({tag, "_dot_valid"}, 64'(dot_valid), 64'd1);
        check({tag, "_dot"}, 64'(dot_out), 64'(exp_dot));
      end
    end
    check({tag, "_dot_held"}, 64'(dot_out), 64'(exp_dot));
  endtask

  initial begin
    int dq[$];
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    len   = '0;
    fill_const(256, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(dot_valid), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_load_old", 64'(load_old), 64'd0);
    check("rst_dot", 64'(dot_out), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < PD; i++) begin
      mem_a[0][i] = DW'(i + 1);
      mem_b[0][i] = DW'(i + 5);
    end
    run_op(1, 1'b0, "len1");
    check("len1_dot70", 64'(dot_out), 64'd70);

    fill_const(3, 255, 255);
    run_op(3, 1'b0, "len3_max");
    check("len3_dot256012", 64'(dot_out), 64'd256012);

    run_op(0, 1'b0, "len0");
    check("len0_dot", 64'(dot_out), 64'd0);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 12);
      fill_rand(n);
      run_op(n, 1'b0, "rand");
    end

    fill_rand(256);
    run_op(256, 1'b0, "len256");

    fill_rand(5);
    run_op(5, 1'b1, "repulse");

    // Reset asserted while reducing; outputs must clear at once.
    fill_rand(3);
    @(negedge clk);
    start = 1'b1;
    len   = 9'd3;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_rd_en", 64'(rd_en), 64'd0);
    check("mid_rst_load_old", 64'(load_old), 64'd0);
    check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
    check("mid_rst_dot", 64'(dot_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_const(2, 1, 1);
    run_op(2, 1'b0, "after_rst");
    check("after_rst_dot8", 64'(dot_out), 64'd8);

    // Start held high: each accept follows one IDLE cycle after DONE.
    for (int i = 0; i < PD; i++) begin
      mem_a[0][i] = DW'(i + 1);
      mem_b[0][i] = DW'(i + 5);
    end
    @(negedge clk);
    start = 1'b1;
    len   = 9'd1;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (done) begin
        dq.push_back(c);
        check("hold_dot", 64'(dot_out), 64'd70);
      end
      if (c == 9 || c == 18) check("hold_idle_gap", 64'(busy), 64'd0);
    end
    start = 1'b0;
    check("hold_done_count", 64'(dq.size()), 64'd3);
    for (int j = 0; j < dq.size() && j < 3; j++)
      check("hold_done_cycle", 64'(dq[j]), 64'(8 + 9 * j));
    repeat (12) @(negedge clk);
    check("final_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_product_ctrl.md
# dot_product_ctrl

Sequencing controller for the parallel multiply-accumulate PE group. On a start request it streams operand chunk addresses to two synchronous operand memories, drives the PE group's `load_old_output` so that the lane accumulators restart on the first chunk and accumulate on every later chunk, and snapshots the lane results at the exact cycle they are final. It then reduces the `para_deg` lanes serially into one scalar dot product. The block sits between the host/top-level control and the PE-group datapath; the PE group's `result` feeds back into its own `old_output` outside this block.

## Interface
- `data_width`, 8, operand element width; PE lanes are `2*data_width` wide
- `para_deg`, 4, number of PE lanes
- `addr_width`, 8, operand memory address width, in chunks
- Derived localparam `OUT_W` = `2*data_width + $clog2(para_deg)`

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request; accepted only in IDLE
- `len`  in  `addr_width+1`  number of chunks, sampled at accept; legal range 0..2^addr_width
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse in DONE
- `rd_en`  out  1  operand memory read enable
- `rd_addr`  out  `addr_width`  chunk address, shared by both operand memories
- `pe_load_old`  out  1  drives PE group `load_old_output`
- `pe_result`  in  `para_deg*2*data_width`  PE group `result` bus; lane i is at `[2*data_width*i +: 2*data_width]`
- `dot_out`  out  `OUT_W`  dot product; held until the next accept
- `dot_valid`  out  1  equal to `done`

## Operation
- States: IDLE, FETCH, DRAIN, REDUCE, DONE.
- IDLE: on `start`, latch `len` and clear `dot_out`. If `len==0`, go to DONE. Otherwise go to FETCH.
- FETCH: lasts `len` cycles. `rd_en=1`, and `rd_addr` counts 0..len-1, one per cycle. The block then goes to DRAIN.
- `pe_load_old` is registered: `pe_load_old <= rd_en && rd_addr!=0`. It is therefore 0 while chunk 0 is at the PE inputs and 1 for chunks 1..len-1.
- DRAIN: lasts 2 cycles with `rd_en=0`. On the clock edge ending the second DRAIN cycle, all lanes of `pe_result` are captured into an internal lane buffer. The state then moves to REDUCE.
- REDUCE: lasts `para_deg` cycles. Cycle i adds lane i, zero-extended to `OUT_W`, into `dot_out`. The state then moves to DONE.
- DONE: lasts 1 cycle. `done=dot_valid=1`. The state then returns to IDLE.
- Arithmetic: all values are unsigned. Lane accumulation wraps modulo 2^(2*data_width) inside the PE group and is not widened here. The lane reduction cannot overflow `OUT_W`.
- `start` is ignored outside IDLE, including DONE. There is no queueing.
- Reset, including assertion mid-operation: state returns to IDLE. `busy`, `done`, `dot_valid`, `rd_en`, `pe_load_old`, `rd_addr`, `dot_out` and the lane buffer all go to 0. In-flight work is discarded. The next operation is correct because its first chunk sees `pe_load_old=0`.

## Timing
- `start` is sampled on the edge ending cycle S. FETCH occupies cycles F = S+1 .. S+len.
- Memory read latency is 1: data for address k is at the PE inputs in cycle F+k+1. The PE register makes the result visible in F+k+2.
- The final lane values are valid only in cycle S+len+2, the last DRAIN cycle. They are captured at the end of that cycle. The PE group overwrites its register every cycle, so this is the only valid capture point.
- For `len>0`, DONE is in cycle S+len+3+para_deg. For `len==0`, DONE is in cycle S+1 with `dot_out=0`.
- The earliest next accept is the IDLE cycle after DONE.

## Structure
- Package `dot_product_pkg` holds the state enum and the `OUT_W` derivation function.
- One natural sub-module is `dot_lane_reducer`. It holds the lane buffer and the serial adder, with capture and step controls. The FSM and address counter stay in the top.

## Test plan
All scenarios use `data_width=8`, `para_deg=4`, with the PE group and two memories in loop.
- `len=1`, a=(1,2,3,4), b=(5,6,7,8) -> `dot_out=70`, `done` at S+8, `pe_load_old` never 1.
- `len=3`, all elements 255 -> each lane 195075 mod 65536 = 64003; `dot_out=256012`; `done` at S+10; `pe_load_old` 0,1,1 on the data cycles.
- `len=0` -> `done` at S+1, `dot_out=0`, `rd_en` never asserted.
- `start` re-pulsed during FETCH and REDUCE -> ignored; exactly one `done`; `rd_addr` sequence 0..len-1 unchanged.
- `reset` low during REDUCE -> all outputs 0 immediately. Then `len=2`, a=b=(1,1,1,1) per chunk -> `dot_out=8`.
- `start` held high continuously with `len=1` -> consecutive accepts separated by exactly one IDLE cycle after each DONE; results identical each time.
